// File: rtl/frequency_generator.sv
// Square-wave stimulus source: N evenly spaced pulses per window of update_period+1 cycles.
// N is loaded as two BCD digits; the half-period is found by repeated subtraction.
module frequency_generator #(
  parameter int unsigned UPDATE_PERIOD = 1200,
  parameter int unsigned BITS          = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      tens,
  input  logic [3:0]      units,
  input  logic            value_load,
  input  logic [BITS-1:0] period,
  input  logic            period_load,
  output logic            signal,
  output logic            window_start,
  output logic            busy
);

  typedef logic [BITS:0] wide_t;
  typedef enum logic [1:0] {RUN, CONV_TENS, CONV_UNITS, DIV} state_t;

  state_t     state, n_state;
  wide_t      update_period, n_update_period;
  wide_t      half, n_half;
  wide_t      k, n_k;
  wide_t      cnt, n_cnt;
  wide_t      rem, n_rem;
  wide_t      q, n_q;
  wide_t      cnt_inc;
  logic [6:0] target, n_target;
  logic [7:0] seg, n_seg;
  logic [7:0] two_n, n_two_n;
  logic [3:0] tens_rem, n_tens_rem;
  logic [3:0] units_q, n_units_q;
  logic       n_signal, n_window_start, n_busy;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign two_n   = {target, 1'b0};
  assign cnt_inc = cnt + wide_t'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      update_period <= wide_t'(UPDATE_PERIOD);
      half          <= '0;
      k             <= '0;
      cnt           <= '0;
      rem           <= '0;
      q             <= '0;
      target        <= '0;
      seg           <= '0;
      tens_rem      <= '0;
      units_q       <= '0;
      signal        <= 1'b0;
      window_start  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= n_state;
      update_period <= n_update_period;
      half          <= n_half;
      k             <= n_k;
      cnt           <= n_cnt;
      rem           <= n_rem;
      q             <= n_q;
      target        <= n_target;
      seg           <= n_seg;
      tens_rem      <= n_tens_rem;
      units_q       <= n_units_q;
      signal        <= n_signal;
      window_start  <= n_window_start;
      busy          <= n_busy;
    end
  end

  // seg tracks floor(k/half), saturating at 2N; cnt is the position within the current half-period.
  always_comb begin
    n_state         = state;
    n_update_period = update_period;
    n_half          = half;
    n_k             = k;
    n_cnt           = cnt;
    n_rem           = rem;
    n_q             = q;
    n_target        = target;
    n_seg           = seg;
    n_tens_rem      = tens_rem;
    n_units_q       = units_q;

    unique case (state)
      RUN: begin
        if (value_load) begin
          n_tens_rem = clamp_bcd(tens);
          n_units_q  = clamp_bcd(units);
          if (period_load) n_update_period = {1'b0, period};
          n_target = '0;
          n_state  = CONV_TENS;
        end else if (period_load) begin
          n_update_period = {1'b0, period};
          n_rem   = {1'b0, period} + wide_t'(1);
          n_q     = '0;
          n_state = DIV;
        end else if (k == update_period) begin
          n_k   = '0;
          n_cnt = '0;
          n_seg = '0;
        end else begin
          n_k = k + wide_t'(1);
          if (cnt_inc == half) begin
            n_cnt = '0;
            if (seg < two_n) n_seg = seg + 8'd1;
          end else begin
            n_cnt = cnt_inc;
          end
        end
      end
      CONV_TENS: begin
        if (tens_rem != 4'd0) begin
          n_target   = target + 7'd10;
          n_tens_rem = tens_rem - 4'd1;
        end else begin
          n_state = CONV_UNITS;
        end
      end
      CONV_UNITS: begin
        n_target = target + {3'b000, units_q};
        n_rem    = update_period + wide_t'(1);
        n_q      = '0;
        n_state  = DIV;
      end
      DIV: begin
        if (target != 7'd0 && rem >= wide_t'(two_n)) begin
          n_rem = rem - wide_t'(two_n);
          n_q   = q + wide_t'(1);
        end else begin
          if (target == 7'd0)  n_half = '0;
          else if (q == '0)    n_half = wide_t'(1);
          else                 n_half = q;
          n_k     = '0;
          n_cnt   = '0;
          n_seg   = '0;
          n_state = RUN;
        end
      end
      default: n_state = RUN;
    endcase

    // Outputs are registered from next-cycle values so they line up with the k they describe.
    n_two_n        = {n_target, 1'b0};
    n_busy         = (n_state != RUN);
    n_window_start = (n_state == RUN) && (n_k == '0);
    n_signal       = (n_state == RUN) && (n_target != 7'd0) && n_seg[0] && (n_seg < n_two_n);
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Bench for frequency_generator: table rows, hand corner sequences and random loads,
// all checked against an arithmetic model of N, W and the half-period.
module tb_frequency_generator;

  logic        clk;
  logic        reset;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic        value_load;
  logic [11:0] period;
  logic        period_load;
  logic        signal;
  logic        window_start;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int mN = 0;
  int mW = 1201;
  int mH = 0;

  typedef struct {
    int t;
    int u;
    bit dv;
    bit dp;
    int per;
    int exp_busy;
    int exp_edges;
  } vec_t;

  vec_t tbl[7];

  frequency_generator #(.UPDATE_PERIOD(1200), .BITS(12)) dut (
    .clk(clk), .reset(reset), .tens(tens), .units(units), .value_load(value_load),
    .period(period), .period_load(period_load), .signal(signal),
    .window_start(window_start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampd(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic int model_q();
    return (mN == 0) ? 0 : mW / (2 * mN);
  endfunction

  function automatic bit model_sig(input int kk);
    int s;
    if (mN == 0) return 1'b0;
    s = kk / mH;
    return (s % 2 == 1) && (s < 2 * mN);
  endfunction

  function automatic int model_edges();
    int n = 0;
    for (int j = 0; j < mN; j++)
      if (mH * (2 * j + 1) < mW) n++;
    return n;
  endfunction

  // Current sample must be window cycle 0; returns positioned at the next window's cycle 0.
  task automatic check_windows(input string tag, input int nwin, input int exp_edges);
    int  edges, bad, first_bad;
    bit  prev;
    prev = 1'b0;
    for (int w = 0; w < nwin; w++) begin
      edges = 0; bad = 0; first_bad = -1;
      for (int kk = 0; kk < mW; kk++) begin
        if (signal !== model_sig(kk) || window_start !== (kk == 0) || busy !== 1'b0) begin
          bad++;
          if (first_bad < 0) first_bad = kk;
        end
        if (signal === 1'b1 && !prev) edges++;
        prev = (signal === 1'b1);
        @(negedge clk);
      end
      chk($sformatf("%s win%0d waveform bad cycles (first k=%0d)", tag, w, first_bad), bad, 0);
      chk($sformatf("%s win%0d edges", tag, w), edges, model_edges());
      if (exp_edges >= 0) chk($sformatf("%s win%0d edges(table)", tag, w), edges, exp_edges);
    end
  endtask

  // Current sample must be the k=0 cycle straight after reset (window_start still low).
  task automatic check_idle(input string tag, input int nwin);
    int bad_ws, bad_sig, bad_busy;
    bad_ws = 0; bad_sig = 0; bad_busy = 0;
    for (int n = 1; n <= nwin * 1201; n++) begin
      @(negedge clk);
      if (window_start !== ((n % 1201) == 0)) bad_ws++;
      if (signal !== 1'b0) bad_sig++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk({tag, " window_start period errors"}, bad_ws, 0);
    chk({tag, " signal high cycles"}, bad_sig, 0);
    chk({tag, " busy high cycles"}, bad_busy, 0);
  endtask

  task automatic do_load(input string tag, input int t, input int u, input bit dv, input bit dp,
                         input int per, input int exp_busy, input int exp_edges,
                         input int nwin, input bit intrude);
    int nb, mq, exp_model_busy;
    logic [31:0] tv, uv, pv;
    tv = t; uv = u; pv = per;
    tens = tv[3:0]; units = uv[3:0]; period = pv[11:0];
    value_load = dv; period_load = dp;
    @(negedge clk);
    value_load = 1'b0; period_load = 1'b0;
    if (dv) mN = clampd(t) * 10 + clampd(u);
    if (dp) mW = per + 1;
    mq = model_q();
    mH = (mN == 0) ? 0 : ((mq < 1) ? 1 : mq);
    exp_model_busy = dv ? (clampd(t) + 1) + 1 + (mq + 1) : mq + 1;
    nb = 0;
    while (busy === 1'b1 && nb < 6000) begin
      if (intrude && nb == 2) begin
        tens = 4'd0; units = 4'd1; value_load = 1'b1; period_load = 1'b1; period = 12'd5;
      end else begin
        value_load = 1'b0; period_load = 1'b0;
      end
      nb++;
      @(negedge clk);
    end
    value_load = 1'b0; period_load = 1'b0;
    chk({tag, " busy length"}, nb, exp_model_busy);
    if (exp_busy >= 0) chk({tag, " busy length(table)"}, nb, exp_busy);
    check_windows(tag, nwin, exp_edges);
  endtask

  initial begin
    tbl[0] = '{t: 2,  u: 5,  dv: 1, dp: 0, per: 0,    exp_busy: 29, exp_edges: 25};
    tbl[1] = '{t: 9,  u: 9,  dv: 1, dp: 1, per: 99,   exp_busy: 12, exp_edges: 50};
    tbl[2] = '{t: 12, u: 15, dv: 1, dp: 1, per: 1200, exp_busy: 18, exp_edges: 99};
    tbl[3] = '{t: 0,  u: 0,  dv: 0, dp: 1, per: 0,    exp_busy: 1,  exp_edges: 0};
    tbl[4] = '{t: 0,  u: 0,  dv: 1, dp: 1, per: 1200, exp_busy: 3,  exp_edges: 0};
    tbl[5] = '{t: 0,  u: 3,  dv: 1, dp: 1, per: 9,    exp_busy: 4,  exp_edges: 3};
    tbl[6] = '{t: 0,  u: 0,  dv: 0, dp: 1, per: 11,   exp_busy: 3,  exp_edges: 3};

    reset = 1'b1; tens = '0; units = '0; period = '0; value_load = 1'b0; period_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset signal", int'(signal), 0);
    chk("reset window_start", int'(window_start), 0);
    reset = 1'b0;
    check_idle("idle", 3);

    for (int i = 0; i < 7; i++)
      do_load($sformatf("row%0d", i), tbl[i].t, tbl[i].u, tbl[i].dv, tbl[i].dp, tbl[i].per,
              tbl[i].exp_busy, tbl[i].exp_edges, 2, 1'b0);

    // N=10, W=1201 -> q=60; a second load mid-conversion must be dropped.
    do_load("busy-drop", 1, 0, 1'b1, 1'b1, 1200, 64, 10, 1, 1'b1);

    // Reset while in DIV (busy cycle 13 of 18 for N=99, W=1201).
    tens = 4'd9; units = 4'd9; period = 12'd1200; value_load = 1'b1; period_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0; period_load = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid-DIV busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("post-reset busy", int'(busy), 0);
    chk("post-reset signal", int'(signal), 0);
    chk("post-reset window_start", int'(window_start), 0);
    reset = 1'b0;
    mN = 0; mW = 1201; mH = 0;
    check_idle("post-reset", 2);

    for (int i = 0; i < 10; i++) begin
      int t, u, per;
      bit dv, dp;
      t   = $urandom_range(0, 15);
      u   = $urandom_range(0, 15);
      per = $urandom_range(0, 300);
      dv  = ($urandom_range(0, 3) != 0);
      dp  = dv ? bit'($urandom_range(0, 1)) : 1'b1;
      do_load($sformatf("rand%0d(t=%0d u=%0d dv=%0d dp=%0d p=%0d)", i, t, u, dv, dp, per),
              t, u, dv, dp, per, -1, -1, 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frequency_generator.md
# frequency_generator

Test-stimulus source producing a square wave with a programmed number of rising edges per measurement window, the transmit-side counterpart of the on-chip frequency counter. A two-digit BCD value N (00–99) and a window length are loaded. The block emits exactly N evenly spaced pulses inside each window of `update_period+1` cycles. `signal` can drive the counter's input directly, either in loopback or as a reference oscillator.

## Interface
- `UPDATE_PERIOD`, 1200: reset value of the window register.
- `BITS`, 12: width of the `period` input.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `tens` in 4: BCD tens digit. Values >9 clamp to 9.
- `units` in 4: BCD units digit. Values >9 clamp to 9.
- `value_load` in 1: single-cycle strobe that captures `tens` and `units`.
- `period` in BITS: new window value.
- `period_load` in 1: single-cycle strobe that captures `period`.
- `signal` out 1: generated waveform.
- `window_start` out 1: high in window cycle 0.
- `busy` out 1: high while converting or dividing. Loads are ignored while `busy` is high.

## Operation
- Registers:
  - `update_period` (BITS+1 bits, zero-extended from `period`).
  - `target` N (7 bits).
  - Half-period H (BITS+1 bits).
  - Window counter k, running 0..`update_period`.
  - Window length W = `update_period`+1.
- Reset values: state RUN, N=0, H=0, k=0, `update_period`=UPDATE_PERIOD, `signal`=0, `window_start`=0, `busy`=0.
- States: RUN, CONV_TENS, CONV_UNITS, DIV.
- Load acceptance, only when `busy`=0:
  - `value_load` (with or without `period_load`): capture the clamped digits, plus `period` if `period_load`=1. Set `target`=0, go to CONV_TENS.
  - `period_load` alone: capture `period`, keep N, go to DIV.
- CONV_TENS: if tens remaining >0, add 10 to `target` and decrement tens remaining. Otherwise go to CONV_UNITS. Duration is tens+1 cycles.
- CONV_UNITS: add units to `target`, go to DIV. Duration is 1 cycle.
- DIV: quotient q by repeated subtraction.
  - Entry: rem=W, q=0.
  - Each cycle: if N>0 and rem ≥ 2N, then rem -= 2N and q++.
  - Otherwise H = max(q,1), or H=0 if N=0. Go to RUN with k=0.
  - Duration is q+1 cycles, or 1 cycle when N=0.
- RUN, per window cycle k:
  - `signal` = 1 iff N>0, floor(k/H) is odd, and floor(k/H) < 2N.
  - `window_start` = (k==0).
  - k wraps from `update_period` to 0.
- Resulting waveform:
  - Rising edges fall at k = H(2j+1), for j = 0..N−1 with k < W.
  - Each pulse is high for H cycles.
  - `signal` is always 0 at k=0, so no pulse straddles a window boundary.
- Edges per window = min(N, floor(W/2) when H=1). When 2N ≤ W, exactly N edges occur.
- Outside RUN: `signal`=0, `window_start`=0, `busy`=1.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- `value_load` accepted at cycle t:
  - `busy` is high from t+1 for (tens+1) + 1 + (q+1) cycles.
  - First `window_start` occurs in the first cycle after `busy` falls.
- `period_load` alone: `busy` is high for q+1 cycles.
- `value_load` and `period_load` in the same cycle: both are captured. Conversion uses the new W.
- A load while `busy`=1 is dropped with no side effect.
- A load during RUN aborts the current window immediately (`signal` goes to 0 next cycle).
- `reset` in any state returns all registers to their reset values next cycle. Nothing resumes.
- `period`=0 gives W=1: `window_start` is constantly high and no edges occur.

## Test plan
- Reset, no loads -> `signal`=0 and `busy`=0 throughout; `window_start` pulses every 1201 cycles; zero rising edges over 3 windows.
- `tens`=2, `units`=5 loaded -> `busy` high for exactly 29 cycles (H=24). Then per window: 25 rising edges at k=24+48j, each high 24 cycles, last falling at k=1200. Repeats over 3 windows.
- `tens`=9, `units`=9, `period`=99 loaded in the same cycle -> N=99, W=100, H=1, `busy` high 12 cycles. Then 50 rising edges per window at odd k.
- `tens`=12, `units`=15 -> clamped to N=99, `busy` high 10+1+7=18 cycles (q=6, H=6). Then 99 edges per 1201-cycle window.
- `tens`=0, `units`=0 -> `busy` high for 3 cycles, then `signal` stays 0 while `window_start` keeps its 1201-cycle period.
- `value_load` asserted while `busy`=1 -> ignored, old N remains in effect. `reset` asserted mid-DIV -> next cycle: RUN, `busy`=0, N=0, `signal`=0.
